split_router: RTL and testbench

- Clocked one-to-two demultiplexer. It is the counterpart of the team's two-to-one merge stage.
- Receives a 1-bit control token, then one data packet, and forwards the packet to output channel 0 or output channel 1.
- Used in the processing-element network wherever one packet stream fans out to two consumers.
- All channels use a valid/ready handshake that mirrors CSP Send/Receive. The forward delay (FL) and backward delay (BL) are expressed as clock cycles.

---
 rtl/split_pkg.sv | 17 +
 rtl/split_delay_cnt.sv | 27 ++
 rtl/split_router.sv | 142 ++++++++++++++
 tb/tb_split_router.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/split_pkg.sv
// Shared types and constants for the split_router one-to-two packet demultiplexer.
package split_pkg;

  localparam int DLY_WIDTH = 8;

  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;

  typedef enum logic [2:0] {
    RECV_CTL,
    RECV_DATA,
    FWD_DELAY,
    SEND,
    BACK_DELAY
  } split_state_t;

endpackage

// File: rtl/split_delay_cnt.sv
// Loadable down-counter with a zero flag; shared by the forward and backward delay phases.
module split_delay_cnt
  import split_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 dec,
  input  logic [DLY_WIDTH-1:0] load_value,
  output logic                 zero
);

  logic [DLY_WIDTH-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_value;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - DLY_WIDTH'(1);
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/split_router.sv
// Clocked 1-to-2 demultiplexer: a control token selects the output channel for the next packet.
module split_router
  import split_pkg::*;
#(
  parameter int WIDTH_PACKAGE = 33,
  parameter int FL            = 2,
  parameter int BL            = 1,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ctl_valid,
  input  logic                     ctl_data,
  output logic                     ctl_ready,
  input  logic                     in_valid,
  input  logic [WIDTH_PACKAGE-1:0] in_data,
  output logic                     in_ready,
  output logic                     out0_valid,
  output logic [WIDTH_PACKAGE-1:0] out0_data,
  input  logic                     out0_ready,
  output logic                     out1_valid,
  output logic [WIDTH_PACKAGE-1:0] out1_data,
  input  logic                     out1_ready,
  output logic [CNT_WIDTH-1:0]     count0,
  output logic [CNT_WIDTH-1:0]     count1,
  output logic                     busy
);

  // Counter is loaded with N-1 so that exactly N cycles are spent in the delay state.
  localparam logic [DLY_WIDTH-1:0] FL_LOAD = (FL > 0) ? DLY_WIDTH'(FL - 1) : '0;
  localparam logic [DLY_WIDTH-1:0] BL_LOAD = (BL > 0) ? DLY_WIDTH'(BL - 1) : '0;

  split_state_t             state_reg, state_next;
  logic                     sel_reg;
  logic [WIDTH_PACKAGE-1:0] data_reg;
  logic                     ctl_ready_reg, in_ready_reg;
  logic                     out0_valid_reg, out1_valid_reg, busy_reg;

  logic                 cnt_load, cnt_dec, cnt_zero;
  logic [DLY_WIDTH-1:0] cnt_load_value;
  logic                 ctl_fire, in_fire, out_fire;

  assign ctl_fire = (state_reg == RECV_CTL) && ctl_valid;
  assign in_fire  = (state_reg == RECV_DATA) && in_valid;
  assign out_fire = (state_reg == SEND) &&
                    ((sel_reg == SEL_OUT1) ? out1_ready : out0_ready);

  split_delay_cnt u_delay (
    .clk        (clk),
    .rst        (reset),
    .load       (cnt_load),
    .dec        (cnt_dec),
    .load_value (cnt_load_value),
    .zero       (cnt_zero)
  );

  always_comb begin
    state_next     = state_reg;
    cnt_load       = 1'b0;
    cnt_dec        = 1'b0;
    cnt_load_value = '0;
    case (state_reg)
      RECV_CTL:   if (ctl_fire) state_next = RECV_DATA;
      RECV_DATA: begin
        if (in_fire) begin
          if (FL > 0) begin
            cnt_load       = 1'b1;
            cnt_load_value = FL_LOAD;
            state_next     = FWD_DELAY;
          end else begin
            state_next = SEND;
          end
        end
      end
      FWD_DELAY: begin
        if (cnt_zero) state_next = SEND;
        else          cnt_dec    = 1'b1;
      end
      SEND: begin
        if (out_fire) begin
          if (BL > 0) begin
            cnt_load       = 1'b1;
            cnt_load_value = BL_LOAD;
            state_next     = BACK_DELAY;
          end else begin
            state_next = RECV_CTL;
          end
        end
      end
      BACK_DELAY: begin
        if (cnt_zero) state_next = RECV_CTL;
        else          cnt_dec    = 1'b1;
      end
      default:    state_next = RECV_CTL;
    endcase
  end

  // Handshake outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= RECV_CTL;
      sel_reg        <= SEL_OUT0;
      data_reg       <= '0;
      ctl_ready_reg  <= 1'b1;
      in_ready_reg   <= 1'b0;
      out0_valid_reg <= 1'b0;
      out1_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      if (ctl_fire) sel_reg  <= ctl_data;
      if (in_fire)  data_reg <= in_data;
      ctl_ready_reg  <= (state_next == RECV_CTL);
      in_ready_reg   <= (state_next == RECV_DATA);
      out0_valid_reg <= (state_next == SEND) && (sel_reg == SEL_OUT0);
      out1_valid_reg <= (state_next == SEND) && (sel_reg == SEL_OUT1);
      busy_reg       <= (state_next != RECV_CTL);
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_count
    logic [CNT_WIDTH-1:0] count_reg;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        count_reg <= '0;
      end else if (out_fire && (sel_reg == 1'(gi))) begin
        count_reg <= count_reg + CNT_WIDTH'(1);
      end
    end
  end

  assign ctl_ready  = ctl_ready_reg;
  assign in_ready   = in_ready_reg;
  assign out0_valid = out0_valid_reg;
  assign out1_valid = out1_valid_reg;
  assign out0_data  = data_reg;
  assign out1_data  = data_reg;
  assign busy       = busy_reg;
  assign count0     = g_count[0].count_reg;
  assign count1     = g_count[1].count_reg;

endmodule

// File: tb/tb_split_router.sv
// Bench for split_router: two instances (FL=2/BL=1/4-bit counters and FL=0/BL=0/16-bit counters).
module tb_split_router;

  localparam int W = 33;

  typedef struct {
    int             inst;
    logic           sel;
    logic [W-1:0]   data;
  } pkt_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst        [2];
  logic         ctl_valid  [2];
  logic         ctl_data   [2];
  logic         in_valid   [2];
  logic [W-1:0] in_data    [2];
  logic         out0_ready [2];
  logic         out1_ready [2];
  logic         ctl_ready  [2];
  logic         in_ready   [2];
  logic         out0_valid [2];
  logic         out1_valid [2];
  logic         busy       [2];
  logic [W-1:0] out0_data  [2];
  logic [W-1:0] out1_data  [2];
  logic [15:0]  count0     [2];
  logic [15:0]  count1     [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int FLP = (gi == 0) ? 2 : 0;
    localparam int BLP = (gi == 0) ? 1 : 0;
    localparam int CW  = (gi == 0) ? 4 : 16;
    logic          cr, ir, v0, v1, b;
    logic [W-1:0]  d0, d1;
    logic [CW-1:0] c0, c1;

    split_router #(.WIDTH_PACKAGE(W), .FL(FLP), .BL(BLP), .CNT_WIDTH(CW)) dut (
      .clk        (clk),
      .reset      (rst[gi]),
      .ctl_valid  (ctl_valid[gi]),
      .ctl_data   (ctl_data[gi]),
      .ctl_ready  (cr),
      .in_valid   (in_valid[gi]),
      .in_data    (in_data[gi]),
      .in_ready   (ir),
      .out0_valid (v0),
      .out0_data  (d0),
      .out0_ready (out0_ready[gi]),
      .out1_valid (v1),
      .out1_data  (d1),
      .out1_ready (out1_ready[gi]),
      .count0     (c0),
      .count1     (c1),
      .busy       (b)
    );

    assign ctl_ready[gi]  = cr;
    assign in_ready[gi]   = ir;
    assign out0_valid[gi] = v0;
    assign out1_valid[gi] = v1;
    assign out0_data[gi]  = d0;
    assign out1_data[gi]  = d1;
    assign busy[gi]       = b;
    assign count0[gi]     = 16'(c0);
    assign count1[gi]     = 16'(c1);
  end

  int   n_checks = 0;
  int   n_pass   = 0;
  int   delivered [2][2];
  pkt_t sb[$];

  function automatic int fl_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic int bl_of(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  function automatic logic [15:0] cnt_exp(input int k, input int ch);
    int m;
    m = (k == 0) ? 16 : 65536;
    return 16'(delivered[k][ch] % m);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One full ctl -> data -> send -> back-off transaction against the scoreboard.
  task automatic run_packet(input int k, input logic sel, input logic [W-1:0] data,
                            input int hold, input bit early_in);
    int           lat;
    pkt_t         p;
    logic [W-1:0] seen;
    @(negedge clk);
    if (early_in) begin
      in_valid[k] = 1'b1;
      in_data[k]  = data;
      repeat (3) begin
        @(negedge clk);
        check("in_ready_before_ctl", 64'(in_ready[k]), 64'd0);
      end
    end
    ctl_valid[k] = 1'b1;
    ctl_data[k]  = sel;
    lat = 0;
    while (!ctl_ready[k] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("ctl_ready_seen", 64'(ctl_ready[k]), 64'd1);
    @(posedge clk);
    @(negedge clk);
    ctl_valid[k] = 1'b0;
    ctl_data[k]  = 1'($urandom);
    in_valid[k]  = 1'b1;
    in_data[k]   = data;
    check("in_ready", 64'(in_ready[k]), 64'd1);
    check("busy", 64'(busy[k]), 64'd1);
    @(posedge clk);
    sb.push_back('{k, sel, data});
    @(negedge clk);
    in_valid[k] = 1'b0;
    in_data[k]  = {1'($urandom), 32'($urandom)};
    lat = 1;
    while (!(out0_valid[k] || out1_valid[k]) && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("fwd_latency", 64'(lat), 64'(fl_of(k) + 1));
    p = sb.pop_front();
    check("out_sel", 64'({out1_valid[k], out0_valid[k]}), p.sel ? 64'd2 : 64'd1);
    seen = p.sel ? out1_data[k] : out0_data[k];
    check("out_data", 64'(seen), 64'(p.data));
    if (p.sel) out0_ready[k] = 1'($urandom);
    else       out1_ready[k] = 1'($urandom);
    repeat (hold) begin
      @(negedge clk);
      seen = p.sel ? out1_data[k] : out0_data[k];
      check("hold_valid", 64'(p.sel ? out1_valid[k] : out0_valid[k]), 64'd1);
      check("hold_data", 64'(seen), 64'(p.data));
      check("hold_other", 64'(p.sel ? out0_valid[k] : out1_valid[k]), 64'd0);
    end
    if (p.sel) out1_ready[k] = 1'b1;
    else       out0_ready[k] = 1'b1;
    @(posedge clk);
    delivered[k][p.sel]++;
    @(negedge clk);
    out0_ready[k] = 1'b0;
    out1_ready[k] = 1'b0;
    check("valid_drop", 64'({out1_valid[k], out0_valid[k]}), 64'd0);
    check("count0", 64'(count0[k]), 64'(cnt_exp(k, 0)));
    check("count1", 64'(count1[k]), 64'(cnt_exp(k, 1)));
    lat = 1;
    while (!ctl_ready[k] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("bwd_latency", 64'(lat), 64'(bl_of(k) + 1));
    $display("pkt inst=%0d sel=%0d data=%09h hold=%0d count0=%0d count1=%0d",
             k, p.sel, p.data, hold, count0[k], count1[k]);
  endtask

  task automatic reset_in_send(input int k);
    @(negedge clk);
    ctl_valid[k] = 1'b1;
    ctl_data[k]  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    ctl_valid[k] = 1'b0;
    in_valid[k]  = 1'b1;
    in_data[k]   = 33'h0_DEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    in_valid[k] = 1'b0;
    repeat (fl_of(k) + 2) @(negedge clk);
    check("rst_pre_send_valid", 64'(out0_valid[k]), 64'd1);
    #2 rst[k] = 1'b1;
    #1;
    check("rst_out0_valid", 64'(out0_valid[k]), 64'd0);
    check("rst_out1_valid", 64'(out1_valid[k]), 64'd0);
    check("rst_ctl_ready", 64'(ctl_ready[k]), 64'd1);
    check("rst_count0", 64'(count0[k]), 64'd0);
    check("rst_data", 64'(out0_data[k]), 64'd0);
    delivered[k][0] = 0;
    delivered[k][1] = 0;
    @(negedge clk);
    rst[k]        = 1'b0;
    out0_ready[k] = 1'b1;
    out1_ready[k] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("post_rst_no_deliver", 64'({out1_valid[k], out0_valid[k]}), 64'd0);
      check("post_rst_count0", 64'(count0[k]), 64'd0);
    end
    out0_ready[k] = 1'b0;
    out1_ready[k] = 1'b0;
    $display("reset-in-send inst=%0d count0=%0d ctl_ready=%0d", k, count0[k], ctl_ready[k]);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k]        = 1'b1;
      ctl_valid[k]  = 1'b0;
      ctl_data[k]   = 1'b0;
      in_valid[k]   = 1'b0;
      in_data[k]    = '0;
      out0_ready[k] = 1'b0;
      out1_ready[k] = 1'b0;
      delivered[k][0] = 0;
      delivered[k][1] = 0;
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      check("reset_ctl_ready", 64'(ctl_ready[k]), 64'd1);
      check("reset_in_ready", 64'(in_ready[k]), 64'd0);
      check("reset_valids", 64'({out1_valid[k], out0_valid[k]}), 64'd0);
      check("reset_counts", 64'({count1[k], count0[k]}), 64'd0);
      check("reset_busy", 64'(busy[k]), 64'd0);
    end
    @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    run_packet(0, 1'b0, 33'h0_0000_00A5, 0, 1'b0);
    run_packet(0, 1'b1, 33'h1_FFFF_FFFF, 10, 1'b0);
    run_packet(0, 1'b1, 33'h0_0000_0042, 0, 1'b1);
    for (int i = 0; i < 4; i++) run_packet(1, 1'(i % 2), 33'(i + 1), 0, 1'b0);
    check("alt_count0", 64'(count0[1]), 64'd2);
    check("alt_count1", 64'(count1[1]), 64'd2);

    reset_in_send(0);
    for (int i = 0; i < 17; i++) run_packet(0, 1'b0, {1'($urandom), 32'($urandom)}, 0, 1'b0);
    check("count0_wrap", 64'(count0[0]), 64'd1);

    for (int i = 0; i < 40; i++) begin
      run_packet($urandom_range(0, 1), 1'($urandom), {1'($urandom), 32'($urandom)},
                 $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
